// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART line-path types, byte constants and width helpers
//
// Contents:
//   line_state_e  : COLLECT / DISCARD / HOLD states of the line assembler
//   UART_CR/LF    : carriage return and line feed byte values
//   uart_len_w    : width needed to count 0..max_len
//   uart_addr_w   : width needed to address max_len entries (minimum 1)
package uart_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DISCARD = 2'd1,
        HOLD    = 2'd2
    } line_state_e;

    localparam logic [7:0] UART_CR = 8'h0D;
    localparam logic [7:0] UART_LF = 8'h0A;

    function automatic int uart_len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    function automatic int uart_addr_w(input int max_len);
        return (max_len > 1) ? $clog2(max_len) : 1;
    endfunction

endpackage

// File: rtl/uart_if.sv
// rtl/uart_if.sv - byte stream interface shared by the UART path blocks
//
// Signals:
//   data[7:0] : byte on the stream
//   valid     : source presents a byte
//   ready     : sink can take the byte; transfer on valid && ready
// Modports: sink (consumer side), source (producer side).
interface UartIF;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport sink   (input data, input valid, output ready);
    modport source (output data, output valid, input ready);
endinterface

// File: rtl/uart_line_buf.sv
// rtl/uart_line_buf.sv - DEPTH x 8 simple dual-port line buffer RAM
//
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (read register only)
//   we, waddr, wdata : synchronous write port
//   raddr, rdata     : registered read port, 1-cycle latency;
//                      raddr >= DEPTH reads 8'h00
// A read and write of the same address on one edge returns the old byte.
module uart_line_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    // No reset on the storage so it maps onto distributed RAM.
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= 8'h00;
        end else if (int'(raddr) < DEPTH) begin
            rdata <= mem[raddr];
        end else begin
            rdata <= 8'h00;
        end
    end

endmodule

// File: rtl/uart_line_rx.sv
// rtl/uart_line_rx.sv - assembles received UART bytes into CR-terminated lines
//
// Parameters: MAX_LEN (buffer depth in bytes), TERM (terminator byte).
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   rxPort      : UartIF sink, byte stream from the receiver
//   txPort      : UartIF source, local echo toward the transmitter
//                 (present only when UART_LINE_ECHO_EN is defined)
//   line_valid  : a completed line is held
//   line_len    : stored byte count of the held line (terminator excluded)
//   line_ovf    : the line was longer than MAX_LEN; extra bytes dropped
//   line_ack    : one-cycle pulse releasing the held line
//   rd_addr     : buffer read address
//   rd_data     : buffer byte at rd_addr, one cycle later
// Build option: UART_LINE_ECHO_EN enables the echo port.
module uart_line_rx
    import uart_pkg::*;
#(
    parameter int         MAX_LEN = 16,
    parameter logic [7:0] TERM    = 8'h0D
) (
    input  logic                               clk,
    input  logic                               rst_n,
    UartIF.sink                                rxPort,
`ifdef UART_LINE_ECHO_EN
    UartIF.source                              txPort,
`endif
    output logic                               line_valid,
    output logic [uart_len_w(MAX_LEN)-1:0]     line_len,
    output logic                               line_ovf,
    input  logic                               line_ack,
    input  logic [uart_addr_w(MAX_LEN)-1:0]    rd_addr,
    output logic [7:0]                         rd_data
);

    localparam int LW = uart_len_w(MAX_LEN);
    localparam int AW = uart_addr_w(MAX_LEN);
    localparam logic [LW-1:0] FULL = LW'(MAX_LEN);

    line_state_e   state;
    logic [LW-1:0] idx;
    logic          accept;
    logic          is_lf;
    logic          is_term;
    logic          buf_we;

`ifdef UART_LINE_ECHO_EN
    // Echo path: the byte is only taken when the transmitter can take it too,
    // so both sides see the same transfer edge.
    assign rxPort.ready = (state != HOLD) && txPort.ready;
    assign txPort.data  = rxPort.data;
    assign txPort.valid = rst_n && (state != HOLD) && rxPort.valid;
`else
    assign rxPort.ready = (state != HOLD);
`endif

    assign accept  = rxPort.valid && rxPort.ready;
    assign is_lf   = (rxPort.data == UART_LF);
    assign is_term = (rxPort.data == TERM);
    assign buf_we  = accept && (state == COLLECT) && !is_lf && !is_term && (idx < FULL);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= COLLECT;
            idx        <= '0;
            line_valid <= 1'b0;
            line_len   <= '0;
            line_ovf   <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    // LF is swallowed everywhere so CRLF terminals behave.
                    if (accept && !is_lf) begin
                        if (is_term) begin
                            // A bare terminator is an empty line and is ignored.
                            if (idx != '0) begin
                                state      <= HOLD;
                                line_valid <= 1'b1;
                                line_len   <= idx;
                                line_ovf   <= 1'b0;
                            end
                        end else if (idx < FULL) begin
                            idx <= idx + 1'b1;
                        end else begin
                            line_ovf <= 1'b1;
                            state    <= DISCARD;
                        end
                    end
                end
                DISCARD: begin
                    if (accept && !is_lf && is_term) begin
                        state      <= HOLD;
                        line_valid <= 1'b1;
                        line_len   <= FULL;
                        line_ovf   <= 1'b1;
                    end
                end
                HOLD: begin
                    if (line_ack) begin
                        state      <= COLLECT;
                        idx        <= '0;
                        line_valid <= 1'b0;
                        line_ovf   <= 1'b0;
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

    uart_line_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (buf_we),
        .waddr (idx[AW-1:0]),
        .wdata (rxPort.data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_uart_line_rx.sv
// tb/tb_uart_line_rx.sv - self-checking bench for uart_line_rx with a line-level reference model
module tb_uart_line_rx;

    localparam int MAX_LEN = 16;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       line_valid;
    logic [4:0] line_len;
    logic       line_ovf;
    logic       line_ack;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;

    int checks = 0;
    int errors = 0;

    // Reference model: the line being typed, as a simple byte list.
    logic [7:0] shadow [MAX_LEN];
    int         m_len;
    bit         m_ovf;

    UartIF rx_if ();
`ifdef UART_LINE_ECHO_EN
    UartIF tx_if ();
`endif

    always #5 clk = ~clk;

    uart_line_rx #(
        .MAX_LEN (MAX_LEN),
        .TERM    (8'h0D)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rxPort     (rx_if),
`ifdef UART_LINE_ECHO_EN
        .txPort     (tx_if),
`endif
        .line_valid (line_valid),
        .line_len   (line_len),
        .line_ovf   (line_ovf),
        .line_ack   (line_ack),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic model_byte(input logic [7:0] b);
        if (b == LF || b == CR) return;
        if (m_len < MAX_LEN) begin
            shadow[m_len] = b;
            m_len++;
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b, output int waits);
        bit ok;
        ok = 1'b0;
        waits = 0;
        rx_if.data  = b;
        rx_if.valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (rx_if.ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            waits++;
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout: byte %02h not accepted, ready=%b required 1", b, rx_if.ready);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        rx_if.valid = 1'b0;
        rx_if.data  = 8'h00;
    endtask

    task automatic ack_line(input string name);
        line_ack = 1'b1;
        @(negedge clk);
        line_ack = 1'b0;
        checks++;
        if (line_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s ack_valid: line_valid=%b required 0", name, line_valid);
        end
        checks++;
        if (rx_if.ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ack_ready: ready=%b required 1", name, rx_if.ready);
        end
    endtask

    // Checks the DUT right after a terminator was accepted.
    task automatic check_line(input string name);
        if (m_len == 0 && !m_ovf) begin
            checks++;
            if (line_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s empty_valid: line_valid=%b required 0", name, line_valid);
            end
            return;
        end
        checks++;
        if (line_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s valid: line_valid=%b required 1", name, line_valid);
        end
        checks++;
        if (line_len !== 5'(m_len)) begin
            errors++;
            $display("FAIL %s len: line_len=%0d required %0d", name, line_len, m_len);
        end
        checks++;
        if (line_ovf !== m_ovf) begin
            errors++;
            $display("FAIL %s ovf: line_ovf=%b required %b", name, line_ovf, m_ovf);
        end
        checks++;
        if (rx_if.ready !== 1'b0) begin
            errors++;
            $display("FAIL %s hold_ready: ready=%b required 0", name, rx_if.ready);
        end
        for (int i = 0; i < m_len; i++) begin
            rd_addr = 4'(i);
            @(negedge clk);
            checks++;
            if (rd_data !== shadow[i]) begin
                errors++;
                $display("FAIL %s data[%0d]: rd_data=%02h required %02h", name, i, rd_data, shadow[i]);
            end
        end
        ack_line(name);
        m_len = 0;
        m_ovf = 1'b0;
    endtask

    task automatic send_str(input string s, input string name);
        int w;
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], w);
            if (s[i] == CR) check_line(name);
            else model_byte(s[i]);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (line_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s valid: line_valid=%b required 0", name, line_valid);
        end
        checks++;
        if (line_len !== 5'd0) begin
            errors++;
            $display("FAIL %s len: line_len=%0d required 0", name, line_len);
        end
        checks++;
        if (line_ovf !== 1'b0) begin
            errors++;
            $display("FAIL %s ovf: line_ovf=%b required 0", name, line_ovf);
        end
        checks++;
        if (rd_data !== 8'h00) begin
            errors++;
            $display("FAIL %s rd_data: rd_data=%02h required 00", name, rd_data);
        end
        checks++;
        if (rx_if.ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready: ready=%b required 1", name, rx_if.ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        m_len = 0;
        m_ovf = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_help();
        send_str("help\r", "help");
    endtask

    task automatic test_empty_lines();
        send_str("\r\n\r", "empty");
        send_str("ab\r\n", "ab");
        send_str("c\r", "after_ab");
    endtask

    task automatic test_overflow();
        int w;
        for (int i = 0; i < 20; i++) begin
            send_byte("x", w);
            model_byte("x");
            checks++;
            if (w != 0) begin
                errors++;
                $display("FAIL ovf_ready[%0d]: stall cycles=%0d required 0", i, w);
            end
            if (i == 16) begin
                checks++;
                if (line_ovf !== 1'b1 || line_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_flag: line_ovf=%b line_valid=%b required 1 0", line_ovf, line_valid);
                end
            end
        end
        send_str("\r", "overflow");
    endtask

    task automatic test_ack_with_valid();
        int w;
        send_str("hi", "ackv");
        send_byte(CR, w);
        checks++;
        if (line_valid !== 1'b1 || line_len !== 5'd2) begin
            errors++;
            $display("FAIL ackv_line: valid=%b len=%0d required 1 2", line_valid, line_len);
        end
        rd_addr = 4'd0;
        rx_if.data  = "q";
        rx_if.valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (rx_if.ready !== 1'b0) begin
                errors++;
                $display("FAIL ackv_stall: ready=%b required 0", rx_if.ready);
            end
        end
        ack_line("ackv");
        @(negedge clk);
        rx_if.valid = 1'b0;
        checks++;
        if (rd_data !== "h") begin
            errors++;
            $display("FAIL ackv_old_byte: rd_data=%02h required %02h", rd_data, 8'h68);
        end
        @(negedge clk);
        checks++;
        if (rd_data !== "q") begin
            errors++;
            $display("FAIL ackv_new_byte: rd_data=%02h required %02h", rd_data, 8'h71);
        end
        m_len = 0;
        m_ovf = 1'b0;
        model_byte("q");
        send_str("\r", "ackv_q");
    endtask

    task automatic test_reset_midline();
        send_str("abc", "midrst");
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        m_len = 0;
        m_ovf = 1'b0;
        @(negedge clk);
        send_str("z\r", "midrst_z");
    endtask

    task automatic test_random();
        int n;
        int w;
        logic [7:0] b;
        for (int line = 0; line < 14; line++) begin
            n = $urandom_range(0, 22);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 7) == 0) send_byte(LF, w);
                b = 8'($urandom_range(32, 126));
                send_byte(b, w);
                model_byte(b);
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            send_byte(CR, w);
            check_line("random");
            if ($urandom_range(0, 1) == 1) send_byte(LF, w);
        end
    endtask

`ifdef UART_LINE_ECHO_EN
    task automatic test_echo();
        rx_if.data  = "k";
        rx_if.valid = 1'b1;
        tx_if.ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (rx_if.ready !== 1'b0 || tx_if.valid !== 1'b1 || tx_if.data !== "k") begin
                errors++;
                $display("FAIL echo_stall: ready=%b txv=%b txd=%02h required 0 1 6b", rx_if.ready, tx_if.valid, tx_if.data);
            end
            @(negedge clk);
        end
        tx_if.ready = 1'b1;
        #1;
        checks++;
        if (rx_if.ready !== 1'b1 || tx_if.valid !== 1'b1 || tx_if.data !== "k") begin
            errors++;
            $display("FAIL echo_release: ready=%b txv=%b txd=%02h required 1 1 6b", rx_if.ready, tx_if.valid, tx_if.data);
        end
        @(negedge clk);
        rx_if.valid = 1'b0;
        model_byte("k");
        send_str("\r", "echo");
    endtask
`endif

    initial begin
        rst_n       = 1'b0;
        line_ack    = 1'b0;
        rd_addr     = 4'd0;
        rx_if.data  = 8'h00;
        rx_if.valid = 1'b0;
`ifdef UART_LINE_ECHO_EN
        tx_if.ready = 1'b1;
`endif
        @(negedge clk);
        test_reset();
        test_help();
        test_empty_lines();
        test_overflow();
        test_ack_with_valid();
        test_reset_midline();
        test_random();
`ifdef UART_LINE_ECHO_EN
        test_echo();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
